// File: rtl/tlc_pkg.sv
// Shared encodings and default timing for the timed traffic-light sequencer.
// Light/phase codes match the existing six-state cycle so downstream monitors decode unchanged.
package tlc_pkg;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    localparam logic [2:0] PH_HG  = 3'd0;
    localparam logic [2:0] PH_HY  = 3'd1;
    localparam logic [2:0] PH_AR1 = 3'd2;
    localparam logic [2:0] PH_CG  = 3'd3;
    localparam logic [2:0] PH_CY  = 3'd4;
    localparam logic [2:0] PH_AR2 = 3'd5;

    localparam int TLC_CW       = 8;
    localparam int TLC_T_HG_MIN = 8;
    localparam int TLC_T_YEL    = 3;
    localparam int TLC_T_AR     = 2;
    localparam int TLC_T_CG_MIN = 4;
    localparam int TLC_T_CG_MAX = 10;

    // Only HG/HY light the highway, so the two roads can never be non-red together.
    function automatic logic [1:0] hwy_light(input logic [2:0] ph);
        logic [1:0] l;
        case (ph)
            PH_HG:   l = LIGHT_GREEN;
            PH_HY:   l = LIGHT_YELLOW;
            default: l = LIGHT_RED;
        endcase
        return l;
    endfunction

    function automatic logic [1:0] cntry_light(input logic [2:0] ph);
        logic [1:0] l;
        case (ph)
            PH_CG:   l = LIGHT_GREEN;
            PH_CY:   l = LIGHT_YELLOW;
            default: l = LIGHT_RED;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tlc_dwell_timer.sv
// Saturating dwell counter: clears on request, otherwise counts up and holds at all-ones.
module tlc_dwell_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // next count: clear wins, then saturate, then increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CW{1'b0}};
        end else if (count_q == {CW{1'b1}}) begin
            count_d = count_q;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tlc_timed_ctrl.sv
// Timed highway/country traffic-light sequencer with car-sensor and pedestrian request latching.
// Phase FSM, request latches and light decode; dwell timing comes from tlc_dwell_timer.
module tlc_timed_ctrl
    import tlc_pkg::*;
#(
    parameter int CW       = TLC_CW,
    parameter int T_HG_MIN = TLC_T_HG_MIN,
    parameter int T_YEL    = TLC_T_YEL,
    parameter int T_AR     = TLC_T_AR,
    parameter int T_CG_MIN = TLC_T_CG_MIN,
    parameter int T_CG_MAX = TLC_T_CG_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_sense,
    input  logic       ped_req,
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam logic [CW-1:0] HG_LAST  = CW'(T_HG_MIN - 1);
    localparam logic [CW-1:0] YEL_LAST = CW'(T_YEL - 1);
    localparam logic [CW-1:0] AR_LAST  = CW'(T_AR - 1);
    localparam logic [CW-1:0] CG_MIN_L = CW'(T_CG_MIN - 1);
    localparam logic [CW-1:0] CG_MAX_L = CW'(T_CG_MAX - 1);

    logic [2:0]    phase_q, phase_d;
    logic          car_q, car_d;
    logic          ped_q, ped_d;
    logic          walk_q, walk_d;
    logic [CW-1:0] tmr;
    logic          phase_chg;

    tlc_dwell_timer #(.CW(CW)) u_dwell (
        .clk   (clk),
        .reset (reset),
        .clr   (phase_chg),
        .count (tmr)
    );

    // phase transitions; unused codes 6/7 fall back to HG
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_HG: begin
                if ((tmr >= HG_LAST) && (car_q || car_sense || ped_q || ped_req)) phase_d = PH_HY;
                else phase_d = PH_HG;
            end
            PH_HY: begin
                if (tmr == YEL_LAST) phase_d = PH_AR1;
                else phase_d = PH_HY;
            end
            PH_AR1: begin
                if (tmr == AR_LAST) phase_d = PH_CG;
                else phase_d = PH_AR1;
            end
            PH_CG: begin
                if (((tmr >= CG_MIN_L) && !car_sense) || (tmr == CG_MAX_L)) phase_d = PH_CY;
                else phase_d = PH_CG;
            end
            PH_CY: begin
                if (tmr == YEL_LAST) phase_d = PH_AR2;
                else phase_d = PH_CY;
            end
            PH_AR2: begin
                if (tmr == AR_LAST) phase_d = PH_HG;
                else phase_d = PH_AR2;
            end
            default: phase_d = PH_HG;
        endcase
    end

    assign phase_chg = (phase_d != phase_q);

    // request latches; a ped_req seen on CG entry is treated as served
    always_comb begin
        car_d  = car_q;
        ped_d  = ped_q;
        walk_d = walk_q;
        if ((phase_q == PH_HG) && (phase_d == PH_HY)) begin
            car_d = 1'b0;
        end else if ((phase_q == PH_HG) && car_sense) begin
            car_d = 1'b1;
        end else begin
            car_d = car_q;
        end
        if ((phase_q == PH_AR1) && (phase_d == PH_CG)) begin
            ped_d  = 1'b0;
            walk_d = ped_q;
        end else if ((phase_q == PH_CG) && (phase_d == PH_CY)) begin
            ped_d  = ped_q | ped_req;
            walk_d = 1'b0;
        end else begin
            ped_d  = ped_q | ped_req;
            walk_d = walk_q;
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_HG;
            car_q   <= 1'b0;
            ped_q   <= 1'b0;
            walk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            car_q   <= car_d;
            ped_q   <= ped_d;
            walk_q  <= walk_d;
        end
    end

    assign hwy         = hwy_light(phase_q);
    assign cntry       = cntry_light(phase_q);
    assign ped_walk    = (phase_q == PH_CG) && walk_q;
    assign ped_pending = ped_q;
    assign phase       = phase_q;

endmodule

// File: tb/tb_tlc_timed_ctrl.sv
// Bench for tlc_timed_ctrl: cycle-level reference model compared every cycle,
// plus hand-computed phase/output checkpoints for the directed scenarios.
module tb_tlc_timed_ctrl;
    import tlc_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       car_sense = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] hwy, cntry;
    logic       ped_walk, ped_pending;
    logic [2:0] phase;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    tlc_timed_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .car_sense   (car_sense),
        .ped_req     (ped_req),
        .hwy         (hwy),
        .cntry       (cntry),
        .ped_walk    (ped_walk),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase index 0..5 = HG,HY,AR1,CG,CY,AR2; lights looked up by phase index.
    int   m_ph = 0, m_t = 0, m_nx;
    bit   m_car = 0, m_ped = 0, m_walk = 0, m_valid = 0;
    logic [1:0] hwy_tab   [6] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] cntry_tab [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};

    function automatic int next_phase(int ph, int t, bit car, bit ped, bit cs, bit pr);
        case (ph)
            0: return (t >= TLC_T_HG_MIN - 1 && (car || cs || ped || pr)) ? 1 : 0;
            1: return (t >= TLC_T_YEL - 1) ? 2 : 1;
            2: return (t >= TLC_T_AR - 1) ? 3 : 2;
            3: return ((t >= TLC_T_CG_MIN - 1 && !cs) || t >= TLC_T_CG_MAX - 1) ? 4 : 3;
            4: return (t >= TLC_T_YEL - 1) ? 5 : 4;
            default: return (t >= TLC_T_AR - 1) ? 0 : 5;
        endcase
    endfunction

    always_comb m_nx = next_phase(m_ph, m_t, m_car, m_ped, car_sense, ped_req);

    always @(posedge clk) begin
        if (reset) begin
            m_ph <= 0; m_t <= 0; m_car <= 0; m_ped <= 0; m_walk <= 0; m_valid <= 1;
        end else begin
            m_ph   <= m_nx;
            m_t    <= (m_nx != m_ph) ? 0 : ((m_t < 255) ? m_t + 1 : m_t);
            m_car  <= (m_ph == 0 && m_nx == 1) ? 1'b0 : ((m_ph == 0 && car_sense) ? 1'b1 : m_car);
            m_ped  <= (m_ph == 2 && m_nx == 3) ? 1'b0 : (ped_req ? 1'b1 : m_ped);
            m_walk <= (m_ph == 2 && m_nx == 3) ? m_ped : ((m_ph == 3 && m_nx == 4) ? 1'b0 : m_walk);
        end
    end

    // per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_phase", {5'd0, phase}, 8'(m_ph));
            chk("model_hwy", {6'd0, hwy}, {6'd0, hwy_tab[m_ph]});
            chk("model_cntry", {6'd0, cntry}, {6'd0, cntry_tab[m_ph]});
            chk("model_ped_walk", {7'd0, ped_walk}, {7'd0, (m_ph == 3) && m_walk});
            chk("model_ped_pending", {7'd0, ped_pending}, {7'd0, m_ped});
            chk("both_roads_not_red", {7'd0, (hwy != 2'b00) && (cntry != 2'b00)}, 8'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic at_cyc(input int k);
        while (cyc < k) step();
    endtask

    task automatic reset_dut();
        car_sense = 1'b0;
        ped_req   = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);

        // 1: idle, no requests -> stays HG
        reset_dut();
        chk("t1_reset_hwy", {6'd0, hwy}, 8'd2);
        chk("t1_reset_cntry", {6'd0, cntry}, 8'd0);
        chk("t1_reset_pending", {7'd0, ped_pending}, 8'd0);
        for (int k = 1; k <= 50; k++) begin
            at_cyc(k);
            chk("t1_idle_phase", {5'd0, phase}, 8'd0);
        end
        chk("t1_idle_hwy", {6'd0, hwy}, 8'd2);
        chk("t1_idle_walk", {7'd0, ped_walk}, 8'd0);

        // 2: car held -> 8/3/2/10/3/2 = 28-cycle loop, CG capped at max
        reset_dut();
        car_sense = 1'b1;
        at_cyc(7);  chk("t2_hg_last", {5'd0, phase}, 8'd0);
        at_cyc(8);  chk("t2_hy", {5'd0, phase}, 8'd1); chk("t2_hy_hwy", {6'd0, hwy}, 8'd1);
        at_cyc(10); chk("t2_hy_last", {5'd0, phase}, 8'd1);
        at_cyc(11); chk("t2_ar1", {5'd0, phase}, 8'd2); chk("t2_ar1_hwy", {6'd0, hwy}, 8'd0);
        at_cyc(13); chk("t2_cg", {5'd0, phase}, 8'd3); chk("t2_cg_cntry", {6'd0, cntry}, 8'd2);
        at_cyc(22); chk("t2_cg_last", {5'd0, phase}, 8'd3);
        at_cyc(23); chk("t2_cy", {5'd0, phase}, 8'd4); chk("t2_cy_cntry", {6'd0, cntry}, 8'd1);
        at_cyc(26); chk("t2_ar2", {5'd0, phase}, 8'd5);
        at_cyc(28); chk("t2_back_hg", {5'd0, phase}, 8'd0);

        // 3: one-cycle car pulse at HG tmr=2 -> CG exactly 4
        reset_dut();
        at_cyc(2); car_sense = 1'b1;
        at_cyc(3); car_sense = 1'b0;
        at_cyc(7);  chk("t3_hg_last", {5'd0, phase}, 8'd0);
        at_cyc(8);  chk("t3_hy", {5'd0, phase}, 8'd1);
        at_cyc(13); chk("t3_cg", {5'd0, phase}, 8'd3);
        at_cyc(16); chk("t3_cg_last", {5'd0, phase}, 8'd3);
        at_cyc(17); chk("t3_cy", {5'd0, phase}, 8'd4);
        at_cyc(22); chk("t3_hg", {5'd0, phase}, 8'd0);
        at_cyc(40); chk("t3_hg_hold", {5'd0, phase}, 8'd0);

        // 4: ped pulse in HG -> walk for all 4 CG cycles
        reset_dut();
        at_cyc(1); ped_req = 1'b1;
        at_cyc(2); ped_req = 1'b0;
        chk("t4_pending", {7'd0, ped_pending}, 8'd1);
        at_cyc(8);  chk("t4_hy", {5'd0, phase}, 8'd1); chk("t4_hy_walk", {7'd0, ped_walk}, 8'd0);
        at_cyc(12); chk("t4_ar1_pending", {7'd0, ped_pending}, 8'd1);
        for (int k = 13; k <= 16; k++) begin
            at_cyc(k);
            chk("t4_cg_walk", {7'd0, ped_walk}, 8'd1);
            chk("t4_cg_pending", {7'd0, ped_pending}, 8'd0);
        end
        at_cyc(17); chk("t4_cy_walk", {7'd0, ped_walk}, 8'd0); chk("t4_cy", {5'd0, phase}, 8'd4);

        // 5: ped during CG with no walk -> served in the next cycle
        reset_dut();
        car_sense = 1'b1;
        at_cyc(1);  car_sense = 1'b0;
        at_cyc(14); chk("t5_cg_no_walk", {7'd0, ped_walk}, 8'd0); ped_req = 1'b1;
        at_cyc(15); ped_req = 1'b0; chk("t5_pending", {7'd0, ped_pending}, 8'd1);
        at_cyc(22); chk("t5_hg", {5'd0, phase}, 8'd0); chk("t5_hg_pending", {7'd0, ped_pending}, 8'd1);
        at_cyc(29); chk("t5_hg_last", {5'd0, phase}, 8'd0);
        at_cyc(30); chk("t5_hy", {5'd0, phase}, 8'd1);
        at_cyc(35); chk("t5_cg", {5'd0, phase}, 8'd3); chk("t5_cg_walk", {7'd0, ped_walk}, 8'd1);
        chk("t5_cg_pending", {7'd0, ped_pending}, 8'd0);

        // 6: reset at CG tmr=5 with ped pending, then a between-edge reset glitch
        reset_dut();
        car_sense = 1'b1;
        at_cyc(14); ped_req = 1'b1;
        at_cyc(15); ped_req = 1'b0;
        at_cyc(18); chk("t6_pre_cg", {5'd0, phase}, 8'd3); chk("t6_pre_pending", {7'd0, ped_pending}, 8'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_phase", {5'd0, phase}, 8'd0);
        chk("t6_hwy", {6'd0, hwy}, 8'd2);
        chk("t6_cntry", {6'd0, cntry}, 8'd0);
        chk("t6_walk", {7'd0, ped_walk}, 8'd0);
        chk("t6_pending", {7'd0, ped_pending}, 8'd0);
        cyc = 0;
        at_cyc(3);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        at_cyc(7); chk("t6_glitch_hg", {5'd0, phase}, 8'd0);
        at_cyc(8); chk("t6_glitch_hy", {5'd0, phase}, 8'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
